ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//   PS/2 host-to-device transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard.
//   It shares the PS/2 clock/data lines with the existing keyboard receiver; both lines are open-drain.
//   tx_busy is routed to the receiver path so that it ignores the line while this block owns it.
// PARAMETERS
//   INHIBIT_CYCLES  5000    clock-low inhibit time in Clock cycles (100 us @ 50 MHz)
//   TIMEOUT_CYCLES  750000  max Clock cycles between device clock edges before abort (15 ms @ 50 MHz)
//   SYNC_STAGES     2       flip-flop depth of the ps2_clk_in/ps2_data_in synchronisers (>=2)
// PORTS
//   Clock               in   1  system clock, 50 MHz
//   Reset               in   1  synchronous, active-high
//   tx_data             in   8  byte to send; latched on accepted tx_start
//   tx_start            in   1  request strobe; accepted only in IDLE
//   tx_busy             out  1  high from the cycle after acceptance until return to IDLE
//   tx_done             out  1  1-cycle pulse: frame complete, ack phase sampled
//   ack_ok              out  1  valid with tx_done: 1 = device acked (data low on 11th edge)
//   tx_error            out  1  1-cycle pulse: timeout abort
//   ps2_clk_in          in   1  raw PS/2 clock line level
//   ps2_data_in         in   1  raw PS/2 data line level
//   ps2_clk_drive_low   out  1  1 = pull PS/2 clock low, 0 = release (tri-stated at top level)
//   ps2_data_drive_low  out  1  1 = pull PS/2 data low, 0 = release
// BEHAVIOUR
//   - Reset: FSM=IDLE; tx_busy, tx_done, ack_ok, tx_error, both drive_low = 0; counters = 0.
//   - Reset mid-frame releases both lines in the same edge; the frame is abandoned with no done/error pulse.
//   - Inputs pass through SYNC_STAGES FFs; fall = synced clk 1 -> 0 (one-cycle strobe).
//   - Shift frame: {stop=1, parity=~^tx_data, tx_data[7:0]}; sent LSB first. Odd parity.
//   - States:
//     IDLE: tx_start=1 -> latch byte, counter=0, clk_drive_low=1 -> INHIBIT.
//     INHIBIT: hold clk low for INHIBIT_CYCLES cycles; at counter==INHIBIT_CYCLES-1 set data_drive_low=1
//       (start bit) -> REQ.
//     REQ: on entry clk_drive_low=0 (clock released one cycle after data low); bit_idx=0, timeout=0 -> SEND.
//     SEND: on each fall drive data_drive_low = ~frame[bit_idx] and increment bit_idx.
//       Falls 1..8 carry data bits 0..7; fall 9 carries parity; fall 10 carries stop (release data) -> ACK.
//     ACK: on the next fall (11th), ack_ok <= ~data_sync -> WAIT_IDLE.
//     WAIT_IDLE: wait until clk_sync=1 and data_sync=1, then pulse tx_done -> IDLE.
//       tx_busy drops in the same cycle tx_done pulses.
//   - Timeout counter clears on REQ entry and on every fall; it counts in SEND/ACK/WAIT_IDLE.
//     At TIMEOUT_CYCLES it releases both lines, pulses tx_error (no tx_done) -> IDLE.
//   - tx_start while not IDLE is ignored; the latched byte is unchanged.
//   - tx_start in the same cycle tx_done pulses is ignored; the earliest new accept is the next cycle.
//   - A NACK (data high on the 11th fall) is not an error: tx_done=1 with ack_ok=0.
//   - Never drive a line high; drive_low outputs are registered (glitch-free).
//   - Counters are sized $clog2(TIMEOUT_CYCLES+1) bits; no wrap in normal use.
// TESTING
//   1 Reset held 3 cycles -> all outputs 0, both lines released.
//     Reset pulsed during SEND at bit 4 -> lines released next edge, no tx_done, tx_error=0.
//   2 tx_start with tx_data=0xED, device model clocking at 12.5 kHz with ack -> clk low for 5000 cycles,
//     data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, tx_done=1, ack_ok=1.
//   3 Parity sweep 0x00->1, 0x01->0, 0xFF->1, 0x80->0, each checked on the 9th fall.
//   4 Device never clocks after REQ -> tx_error pulse exactly TIMEOUT_CYCLES after REQ entry, lines released,
//     tx_busy=0.
//   5 Device leaves data high on the 11th fall -> tx_done=1, ack_ok=0, tx_error=0.
//   6 tx_start pulsed during SEND with 0x55 -> ignored; the frame in flight is unchanged and no second frame
//     is sent.

Source files
------------

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Inhibits the bus, issues a request-to-send, then clocks out an odd-parity frame on device clock falls.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_start,
    output logic       o_tx_busy,
    output logic       o_tx_done,
    output logic       o_ack_ok,
    output logic       o_tx_error,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_data_in,
    output logic       o_ps2_clk_drive_low,
    output logic       o_ps2_data_drive_low
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic [7:0]             r_data;
    logic [3:0]             r_bit_idx;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_clk_low;
    logic                   r_data_low;
    logic                   r_tx_done;
    logic                   r_tx_error;
    logic                   r_ack_ok;

    logic       w_clk_s;
    logic       w_data_s;
    logic       w_fall;
    logic       w_line_idle;
    logic       w_counting;
    logic       w_timeout;
    logic       w_accept;
    logic [9:0] w_frame;

    assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_fall      = r_clk_prev & ~w_clk_s;
    assign w_line_idle = w_clk_s & w_data_s;
    assign w_frame     = {1'b1, ~^r_data, r_data};
    // A request arriving in the done cycle is dropped so the receiver sees at least one idle cycle.
    assign w_accept    = (r_state == S_IDLE) && i_tx_start && !r_tx_done;
    assign w_counting  = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_timeout   = w_counting && !w_fall && (r_cnt == TO_LAST);

    assign o_tx_busy            = (r_state != S_IDLE);
    assign o_tx_done            = r_tx_done;
    assign o_tx_error           = r_tx_error;
    assign o_ack_ok             = r_ack_ok;
    assign o_ps2_clk_drive_low  = r_clk_low;
    assign o_ps2_data_drive_low = r_data_low;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_accept) w_next = S_INHIBIT;
            S_INHIBIT:   if (r_cnt == INH_LAST) w_next = S_REQ;
            S_REQ:       w_next = S_SEND;
            S_SEND: begin
                if (w_timeout) w_next = S_IDLE;
                else if (w_fall && (r_bit_idx == 4'd9)) w_next = S_ACK;
            end
            S_ACK: begin
                if (w_timeout) w_next = S_IDLE;
                else if (w_fall) w_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: if (w_line_idle || w_timeout) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
            r_data      <= '0;
            r_bit_idx   <= '0;
            r_cnt       <= '0;
            r_clk_low   <= 1'b0;
            r_data_low  <= 1'b0;
            r_tx_done   <= 1'b0;
            r_tx_error  <= 1'b0;
            r_ack_ok    <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk_in};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i_ps2_data_in};
            r_clk_prev  <= w_clk_s;
            r_tx_done   <= 1'b0;
            r_tx_error  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_data    <= i_tx_data;
                        r_cnt     <= '0;
                        r_clk_low <= 1'b1;
                        r_ack_ok  <= 1'b0;
                    end
                end
                S_INHIBIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == INH_LAST) begin
                        r_cnt      <= '0;
                        r_data_low <= 1'b1;
                    end
                end
                S_REQ: begin
                    r_clk_low <= 1'b0;
                    r_bit_idx <= '0;
                    r_cnt     <= r_cnt + 1'b1;
                end
                S_SEND, S_ACK, S_WAIT_IDLE: begin
                    if ((r_state == S_WAIT_IDLE) && w_line_idle) begin
                        r_tx_done <= 1'b1;
                    end else if (w_timeout) begin
                        r_clk_low  <= 1'b0;
                        r_data_low <= 1'b0;
                        r_tx_error <= 1'b1;
                    end else if (w_fall) begin
                        r_cnt <= '0;
                        if (r_state == S_SEND) begin
                            r_data_low <= ~w_frame[r_bit_idx];
                            r_bit_idx  <= r_bit_idx + 1'b1;
                        end
                        if (r_state == S_ACK) r_ack_ok <= ~w_data_s;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int TOUT = 600;
    localparam int H    = 20;
    localparam logic [31:0] PAR_BYTES = 32'h00_01_FF_80;
    localparam logic [3:0]  PAR_EXP   = 4'b1010;

    logic       clk          = 1'b0;
    logic       rst          = 1'b1;
    logic [7:0] tx_data      = 8'h00;
    logic       tx_start     = 1'b0;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       o_tx_busy, o_tx_done, o_ack_ok, o_tx_error;
    logic       o_clk_low, o_data_low;
    logic       line_clk, line_data;

    logic m_busy    = 1'b0;
    logic m_done_ok = 1'b0;
    logic m_err_ok  = 1'b0;
    logic m_ack     = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    assign line_clk  = ~(o_clk_low | dev_clk_low);
    assign line_data = ~(o_data_low | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TOUT),
        .SYNC_STAGES(2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_tx_data(tx_data),
        .i_tx_start(tx_start),
        .o_tx_busy(o_tx_busy),
        .o_tx_done(o_tx_done),
        .o_ack_ok(o_ack_ok),
        .o_tx_error(o_tx_error),
        .i_ps2_clk_in(line_clk),
        .i_ps2_data_in(line_data),
        .o_ps2_clk_drive_low(o_clk_low),
        .o_ps2_data_drive_low(o_data_low)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame as the device must see it: data LSB first, odd parity, stop bit.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (o_tx_done || o_tx_error) check("busy_at_end", 32'(o_tx_busy), 0);
            else check("busy", 32'(o_tx_busy), 32'(m_busy));
            check("done_window", 32'(o_tx_done & ~m_done_ok), 0);
            check("error_window", 32'(o_tx_error & ~m_err_ok), 0);
            if (!m_busy) check("lines_released", 32'({o_clk_low, o_data_low}), 0);
            if (o_tx_done) check("ack_with_done", 32'(o_ack_ok), 32'(m_ack));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic start_frame(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        m_busy   = 1'b1;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_request();
        int n = 0;
        while (o_clk_low && !o_data_low && n < INH + 10) begin
            n++;
            tick(1);
        end
        check("inhibit_len", 32'(n), 32'(INH));
        check("start_bit_with_clk_low", 32'({o_clk_low, o_data_low}), 32'h3);
        tick(1);
        check("clk_released_after_start", 32'({o_clk_low, o_data_low}), 32'h1);
    endtask

    task automatic timeout_phase();
        int n = 1;
        wait_request();
        m_err_ok = 1'b1;
        while (!o_tx_error && n < TOUT + 50) begin
            tick(1);
            n++;
        end
        check("timeout_cycles", 32'(n), 32'(TOUT));
        check("timeout_lines", 32'({o_clk_low, o_data_low}), 0);
        check("timeout_busy_done", 32'({o_tx_busy, o_tx_done}), 0);
        m_busy = 1'b0;
        tick(1);
        m_err_ok = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] d, input bit ack, input int rst_at, input bit poke,
                             input bit chain, output logic [9:0] got);
        int n;
        got = '0;
        start_frame(d);
        wait_request();
        tick(H);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == rst_at) begin
                tick(H / 2);
                rst    = 1'b1;
                m_busy = 1'b0;
                tick(1);
                check("reset_lines", 32'({o_clk_low, o_data_low}), 0);
                check("reset_flags", 32'({o_tx_busy, o_tx_done, o_tx_error, o_ack_ok}), 0);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                tick(2);
                rst = 1'b0;
                tick(4 * H);
                return;
            end
            if (poke && k == 5) begin
                tick(3);
                tx_data  = 8'h55;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
                tick(H - 4);
            end else begin
                tick(H);
            end
            if (k <= 10) got[k-1] = line_data;
            dev_clk_low = 1'b0;
            if (k == 10) dev_data_low = ack;
            if (k == 11) begin
                m_ack     = ack;
                m_done_ok = 1'b1;
            end else begin
                tick(H);
            end
        end
        n = 0;
        while (!o_tx_done && n < 4 * H) begin
            tick(1);
            n++;
            if (n == H) dev_data_low = 1'b0;
        end
        dev_data_low = 1'b0;
        check("done_seen", 32'(o_tx_done), 1);
        check("ack_ok", 32'(o_ack_ok), 32'(ack));
        check("frame_bits", 32'(got), 32'(model_frame(d)));
        m_busy = 1'b0;
        if (chain) begin
            tx_data  = 8'h3C;
            tx_start = 1'b1;
        end
        tick(1);
        m_done_ok = 1'b0;
        if (chain) begin
            check("start_in_done_cycle_ignored", 32'(o_tx_busy), 0);
            tick(1);
            tx_start = 1'b0;
            check("start_next_cycle_accepted", 32'(o_tx_busy), 1);
            m_busy = 1'b1;
            timeout_phase();
        end
    endtask

    initial begin
        logic [9:0] got;
        logic [7:0] b;
        rst = 1'b1;
        tick(3);
        check("reset_outputs", 32'({o_tx_busy, o_tx_done, o_ack_ok, o_tx_error, o_clk_low, o_data_low}), 0);
        rst = 1'b0;
        tick(2);

        run_frame(8'hED, 1'b1, 0, 1'b0, 1'b0, got);
        check("ed_frame_literal", 32'(got), 32'h3ED);

        for (int i = 0; i < 4; i++) begin
            b = PAR_BYTES[31-8*i -: 8];
            run_frame(b, 1'b1, 0, 1'b0, 1'b0, got);
            check("parity_9th_fall", 32'(got[8]), 32'(PAR_EXP[3-i]));
        end

        for (int i = 0; i < 6; i++) begin
            run_frame(8'($urandom), 1'($urandom), 0, 1'b0, 1'b0, got);
            tick($urandom_range(0, 5));
        end

        run_frame(8'h5A, 1'b0, 0, 1'b0, 1'b0, got);

        run_frame(8'hA3, 1'b1, 0, 1'b1, 1'b0, got);
        check("poke_frame_literal", 32'(got), 32'h3A3);
        tick(3 * INH);
        check("no_second_frame", 32'({o_tx_busy, o_clk_low, o_data_low}), 0);

        run_frame(8'h12, 1'b1, 0, 1'b0, 1'b1, got);
        tick(5);

        run_frame(8'hC7, 1'b1, 4, 1'b0, 1'b0, got);
        check("after_reset_quiet", 32'({o_tx_busy, o_tx_done, o_tx_error}), 0);

        run_frame(8'($urandom), 1'b1, 0, 1'b0, 1'b0, got);
        tick(10);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
